// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared codes, constants and state encodings for the fetch stage
package fetch_stage_pkg;

    localparam logic [2:0] PC_SEL_HOLD   = 3'b000;
    localparam logic [2:0] PC_SEL_PC4    = 3'b001;
    localparam logic [2:0] PC_SEL_BRANCH = 3'b010;
    localparam logic [2:0] PC_SEL_JUMP   = 3'b011;
    localparam logic [2:0] PC_SEL_TRAP   = 3'b100;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HELD    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_e;

    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JUMP) || (sel == PC_SEL_TRAP);
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with write-enable and kill-to-bubble
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic        kill,
    input  logic        load_valid,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc    <= 32'h0000_0000;
            ifid_pc4   <= 32'h0000_0004;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (write_en) begin
            // Bubbles still carry the current pc so downstream debug sees a sane address
            ifid_pc  <= load_pc;
            ifid_pc4 <= load_pc + 32'd4;
            if (!kill && load_valid) begin
                ifid_instr <= load_instr;
                ifid_valid <= 1'b1;
            end else begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch FSM, PC and skid buffer feeding the IF/ID register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_sel,
    input  logic        ifid_write,
    input  logic        kill_if,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] trap_vector,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        if_stall
);

    fetch_state_e state, state_next;

    logic [31:0] pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        advance;
    logic        deliver;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_instr;

    assign redirect = is_redirect(pc_sel);
    assign advance  = ifid_write && (pc_sel != PC_SEL_HOLD);

    always_comb begin
        redirect_pc = pc;
        case (pc_sel)
            PC_SEL_BRANCH: redirect_pc = {branch_target[31:2], 2'b00};
            PC_SEL_JUMP:   redirect_pc = {jump_target[31:2], 2'b00};
            PC_SEL_TRAP:   redirect_pc = {trap_vector[31:2], 2'b00};
            default:       redirect_pc = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:  state_next = ST_REQ;
            ST_REQ:  state_next = redirect ? ST_DISCARD : ST_WAIT;
            ST_WAIT: begin
                if (imem_valid) begin
                    state_next = (redirect || advance) ? ST_REQ : ST_HELD;
                end else if (redirect) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_HELD: begin
                if (redirect || advance) begin
                    state_next = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (imem_valid) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_RST;
        endcase
    end

    always_comb begin
        imem_req      = 1'b0;
        if_stall      = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = pc;
        deliver_instr = imem_rdata;
        case (state)
            ST_REQ: begin
                imem_req = 1'b1;
                if_stall = 1'b1;
            end
            ST_WAIT: begin
                if_stall = 1'b1;
                deliver  = imem_valid && advance && !redirect;
            end
            ST_HELD: begin
                deliver       = advance && !redirect;
                deliver_pc    = buf_pc;
                deliver_instr = buf_instr;
            end
            ST_DISCARD: if_stall = 1'b1;
            default: ;
        endcase
    end

    // pc only moves on a redirect or when an instruction is actually handed to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (deliver) begin
            pc <= deliver_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_pc    <= RESET_PC;
            buf_instr <= NOP_INSTR;
        end else if (state == ST_WAIT && imem_valid && !redirect && !advance) begin
            buf_pc    <= pc;
            buf_instr <= imem_rdata;
        end
    end

    assign imem_addr = pc;

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (ifid_write),
        .kill       (kill_if),
        .load_valid (deliver),
        .load_pc    (deliver_pc),
        .load_instr (deliver_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NVEC = 25;

    typedef struct {
        logic [2:0]  sel;
        logic        wr;
        logic        kill;
        logic        vld;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pc_sel = 3'b001;
    logic        ifid_write = 1'b1;
    logic        kill_if = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] trap_vector = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        if_stall;

    int tests = 0;
    int fails = 0;
    vec_t vecs [NVEC];

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_sel        (pc_sel),
        .ifid_write    (ifid_write),
        .kill_if       (kill_if),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .trap_vector   (trap_vector),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .if_stall      (if_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] sel, input logic wr, input logic kill,
                                input logic vld, input logic [31:0] tgt, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                                input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.sel = sel; v.wr = wr; v.kill = kill; v.vld = vld; v.tgt = tgt; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic drive(input logic [2:0] sel, input logic wr, input logic kill,
                         input logic vld, input logic [31:0] tgt, input logic [31:0] rdata);
        pc_sel = sel; ifid_write = wr; kill_if = kill; imem_valid = vld; imem_rdata = rdata;
        branch_target = tgt; jump_target = tgt; trap_vector = tgt;
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_stall, input logic e_valid,
                                 input logic [31:0] e_pc, input logic [31:0] e_instr);
        logic [31:0] e_pc4;
        check({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
        check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".if_stall"}, {31'b0, if_stall}, {31'b0, e_stall});
        check({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, e_valid});
        check({tag, ".ifid_instr"}, ifid_instr, e_instr);
        // pc fields are only meaningful when decode sees a real instruction
        if (e_valid) begin
            e_pc4 = e_pc + 32'd4;
            check({tag, ".ifid_pc"}, ifid_pc, e_pc);
            check({tag, ".ifid_pc4"}, ifid_pc4, e_pc4);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".imem_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, ".imem_addr"}, imem_addr, 32'h0);
        check({tag, ".if_stall"}, {31'b0, if_stall}, 32'd0);
        check({tag, ".ifid_pc"}, ifid_pc, 32'h0);
        check({tag, ".ifid_pc4"}, ifid_pc4, 32'h4);
        check({tag, ".ifid_instr"}, ifid_instr, NOP);
        check({tag, ".ifid_valid"}, {31'b0, ifid_valid}, 32'd0);
    endtask

    initial begin
        //             sel  wr kl vl tgt            rdata         | req addr          stl vld pc             instr
        vecs[0]  = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         1, 32'h0,         1, 0, 32'h0,         NOP);
        vecs[1]  = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'h0,         1, 0, 32'h0,         NOP);
        vecs[2]  = mk(3'd1, 1, 0, 1, 32'h0,        32'h00500093,  1, 32'h4,         1, 1, 32'h0,         32'h00500093);
        vecs[3]  = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'h4,         1, 0, 32'h0,         NOP);
        vecs[4]  = mk(3'd2, 1, 0, 1, 32'h103,      32'h00A00113,  1, 32'h100,       1, 0, 32'h0,         NOP);
        vecs[5]  = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'h100,       1, 0, 32'h0,         NOP);
        vecs[6]  = mk(3'd3, 1, 0, 0, 32'h200,      32'h0,         0, 32'h200,       1, 0, 32'h0,         NOP);
        vecs[7]  = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'h200,       1, 0, 32'h0,         NOP);
        vecs[8]  = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'h200,       1, 0, 32'h0,         NOP);
        vecs[9]  = mk(3'd1, 1, 0, 1, 32'h0,        32'hDEADBEEF,  1, 32'h200,       1, 0, 32'h0,         NOP);
        vecs[10] = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'h200,       1, 0, 32'h0,         NOP);
        vecs[11] = mk(3'd1, 1, 0, 1, 32'h0,        32'h00108093,  1, 32'h204,       1, 1, 32'h200,       32'h00108093);
        vecs[12] = mk(3'd0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h204,       1, 1, 32'h200,       32'h00108093);
        vecs[13] = mk(3'd0, 0, 0, 1, 32'h0,        32'h00208113,  0, 32'h204,       0, 1, 32'h200,       32'h00108093);
        vecs[14] = mk(3'd0, 0, 0, 0, 32'h0,        32'h0,         0, 32'h204,       0, 1, 32'h200,       32'h00108093);
        vecs[15] = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         1, 32'h208,       1, 1, 32'h204,       32'h00208113);
        vecs[16] = mk(3'd0, 0, 1, 0, 32'h0,        32'h0,         0, 32'h208,       1, 1, 32'h204,       32'h00208113);
        vecs[17] = mk(3'd1, 1, 1, 1, 32'h0,        32'h00310193,  1, 32'h20C,       1, 0, 32'h0,         NOP);
        vecs[18] = mk(3'd4, 1, 0, 0, 32'hFFFFFFFE, 32'h0,         0, 32'hFFFFFFFC,  1, 0, 32'h0,         NOP);
        vecs[19] = mk(3'd1, 1, 0, 1, 32'h0,        32'hCAFEF00D,  1, 32'hFFFFFFFC,  1, 0, 32'h0,         NOP);
        vecs[20] = mk(3'd1, 1, 0, 0, 32'h0,        32'h0,         0, 32'hFFFFFFFC,  1, 0, 32'h0,         NOP);
        vecs[21] = mk(3'd1, 1, 0, 1, 32'h0,        32'h00000073,  1, 32'h0,         1, 1, 32'hFFFFFFFC,  32'h00000073);
        vecs[22] = mk(3'd1, 0, 0, 0, 32'h0,        32'h0,         0, 32'h0,         1, 1, 32'hFFFFFFFC,  32'h00000073);
        vecs[23] = mk(3'd0, 0, 0, 1, 32'h0,        32'h11111111,  0, 32'h0,         0, 1, 32'hFFFFFFFC,  32'h00000073);
        vecs[24] = mk(3'd3, 1, 0, 0, 32'h300,      32'h0,         1, 32'h300,       1, 0, 32'h0,         NOP);

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].sel, vecs[i].wr, vecs[i].kill, vecs[i].vld, vecs[i].tgt, vecs[i].rdata);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_stall,
                          vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
        end

        // REQ -> WAIT, then async reset in the middle of the outstanding fetch
        drive(3'd1, 1, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");

        // Late responses in RST and REQ must be ignored; the next real one is delivered
        #2;
        drive(3'd1, 1, 0, 1, 32'h0, 32'hBAD0BAD0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst_rst", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, NOP);
        @(posedge clk);
        #1;
        check_outputs("post_rst_req", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, NOP);
        drive(3'd1, 1, 0, 1, 32'h0, 32'h00500093);
        @(posedge clk);
        #1;
        check_outputs("post_rst_wait", 1'b1, 32'h4, 1'b1, 1'b1, 32'h0, 32'h00500093);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
